// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic pipeline register with 2-entry skid buffer, flush and bubble-NOP control
// Optional stall counter (stall_cnt port) is built only when STALL_CNT_EN is defined.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]        state;
  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              in_ready_r;
  logic              acc;
  logic              tak;

  assign acc = in_valid & in_ready_r;
  assign tak = main_valid & out_ready;

  // Control words are zeroed whenever their slot empties, so out_ctrl needs no gating
  assign in_ready  = in_ready_r;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      main_valid <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
      in_ready_r <= 1'b1;
    end else if (flush) begin
      state      <= EMPTY;
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      in_ready_r <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            state      <= BUSY;
            main_valid <= 1'b1;
            main_data  <= in_data;
            main_ctrl  <= in_ctrl;
          end
        end
        BUSY: begin
          if (acc && tak) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
          end else if (acc) begin
            state      <= FULL;
            skid_valid <= 1'b1;
            skid_data  <= in_data;
            skid_ctrl  <= in_ctrl;
            in_ready_r <= 1'b0;
          end else if (tak) begin
            state      <= EMPTY;
            main_valid <= 1'b0;
            main_ctrl  <= '0;
          end
        end
        FULL: begin
          if (tak) begin
            state      <= BUSY;
            main_data  <= skid_data;
            main_ctrl  <= skid_ctrl;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            in_ready_r <= 1'b1;
          end
        end
        default: begin
          state      <= EMPTY;
          main_valid <= 1'b0;
          main_ctrl  <= '0;
          skid_valid <= 1'b0;
          skid_ctrl  <= '0;
          in_ready_r <= 1'b1;
        end
      endcase
    end
  end

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;

  // Saturating; flush deliberately leaves it alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= '0;
    end else if (main_valid && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule
